stack_controller: RTL

- Hardware LIFO controller serving the MIPSCPU call/return and push/pop stack.
- Owns the stack storage, the stack pointer and the top-of-stack register.
- Arbitrates simultaneous push/pop requests from the CPU control unit in a single cycle.
- Generates the stack_overflow flag exported at the CPU top level, plus an underflow flag.

---
 rtl/stack_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stack_controller.sv
// LIFO controller: stack storage, stack pointer, top-of-stack register and overflow/underflow flags.
// Define STACK_STICKY_OVF_EN to make stack_overflow/stack_underflow sticky until reset.
module stack_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_TWO   = PTR_WIDTH'(2);
  localparam logic [PTR_WIDTH:0]   CNT_ONE   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   CNT_TWO   = (PTR_WIDTH+1)'(2);
  localparam logic [PTR_WIDTH:0]   CNT_DEPTH = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  sp;

  logic [PTR_WIDTH-1:0]  sp_nxt;
  logic [PTR_WIDTH:0]    count_nxt;
  logic [DATA_WIDTH-1:0] tos_nxt;
  logic                  we;
  logic [PTR_WIDTH-1:0]  waddr;
  logic [PTR_WIDTH-1:0]  top_addr;
  logic [PTR_WIDTH-1:0]  below_addr;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  ovf_nxt;
  logic                  udf_nxt;

  assign top_addr   = sp - PTR_ONE;
  assign below_addr = sp - PTR_TWO;

  // Decode {push,pop} into next pointer/count/top-of-stack and the write request.
  always_comb begin
    sp_nxt    = sp;
    count_nxt = count;
    tos_nxt   = tos;
    we        = 1'b0;
    waddr     = sp;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          we        = 1'b1;
          waddr     = sp;
          sp_nxt    = sp + PTR_ONE;
          count_nxt = count + CNT_ONE;
          tos_nxt   = din;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_nxt    = top_addr;
          count_nxt = count - CNT_ONE;
          if (count >= CNT_TWO) begin
            tos_nxt = mem[below_addr];
          end else begin
            tos_nxt = {DATA_WIDTH{1'b0}};
          end
        end else begin
          udf_evt = 1'b1;
        end
      end
      2'b11: begin
        // Simultaneous push+pop overwrites the top entry; on an empty stack it is a plain push.
        if (!empty) begin
          we      = 1'b1;
          waddr   = top_addr;
          tos_nxt = din;
        end else begin
          we        = 1'b1;
          waddr     = sp;
          sp_nxt    = sp + PTR_ONE;
          count_nxt = count + CNT_ONE;
          tos_nxt   = din;
        end
      end
      default: begin
        sp_nxt = sp;
      end
    endcase
`ifdef STACK_STICKY_OVF_EN
    ovf_nxt = stack_overflow | ovf_evt;
    udf_nxt = stack_underflow | udf_evt;
`else
    ovf_nxt = ovf_evt;
    udf_nxt = udf_evt;
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp              <= {PTR_WIDTH{1'b0}};
      count           <= {(PTR_WIDTH+1){1'b0}};
      tos             <= {DATA_WIDTH{1'b0}};
      empty           <= 1'b1;
      full            <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      sp              <= sp_nxt;
      count           <= count_nxt;
      tos             <= tos_nxt;
      empty           <= (count_nxt == {(PTR_WIDTH+1){1'b0}});
      full            <= (count_nxt == CNT_DEPTH);
      stack_overflow  <= ovf_nxt;
      stack_underflow <= udf_nxt;
    end
  end

  // Storage is not cleared by reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      mem[waddr] <= din;
    end else begin
      mem[waddr] <= mem[waddr];
    end
  end

endmodule
